// File: rtl/dht11_scheduler.sv
// dht11_scheduler: sequences DHT11 measurements for the APB peripheral.
// It issues a one-cycle start pulse to the reader, either periodically or
// on a software request, then waits a fixed conversion window. It samples
// the reader outputs, retries implausible data and holds the last good
// reading along with valid/error/interrupt status.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   en             enables periodic triggering
//   req_now        one-shot software measurement request (ignored when busy)
//   irq_clr        clears irq (a simultaneous set wins)
//   humidity_in    reader humidity    {int, frac}
//   temperature_in reader temperature {int, frac}
//   dht_start      one-cycle start pulse to the reader
//   humidity       last accepted humidity
//   temperature    last accepted temperature
//   valid          humidity/temperature hold an accepted sample
//   busy           high in every state except IDLE
//   err            sticky error, retries exhausted
//   err_count      saturating count of failed samples
//   irq            level interrupt, set on accept or on error
//
// Build option: DHT_SCHED_PLAUSIBILITY_EN enables the range check and the
// retry/error path. When it is undefined every sample is accepted.
module dht11_scheduler #(
    parameter int CLK_DIV   = 100,
    parameter int US_PER_MS = 1000,
    parameter int PERIOD_MS = 2000,
    parameter int WINDOW_MS = 30,
    parameter int RETRY_MS  = 1000,
    parameter int MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req_now,
    input  logic        irq_clr,
    input  logic [15:0] humidity_in,
    input  logic [15:0] temperature_in,
    output logic        dht_start,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        valid,
    output logic        busy,
    output logic        err,
    output logic [7:0]  err_count,
    output logic        irq
);

`ifdef DHT_SCHED_PLAUSIBILITY_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam int US_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SUB_W = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
    localparam int MS_PW =
        (PERIOD_MS > RETRY_MS) ? PERIOD_MS : RETRY_MS;
    localparam int MS_MAX =
        (MS_PW > WINDOW_MS) ? MS_PW : WINDOW_MS;
    localparam int MS_W = $clog2(MS_MAX + 1);
    localparam int RT_W =
        (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRIG  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t            state;
    logic [US_W-1:0]   us_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [RT_W-1:0]   retry_cnt;

    logic timer_run;
    logic us_wrap;
    logic sub_wrap;
    logic ms_tick;
    logic period_done;
    logic window_done;
    logic retry_done;
    logic leave;
    logic in_range;
    logic sample_ok;

    // The time base only runs in the timed states; in IDLE it runs only
    // while periodic triggering is enabled, so it sits at 0 otherwise.
    always_comb begin
        timer_run = 1'b0;
        unique case (state)
            IDLE:      timer_run = en;
            WAIT, GAP: timer_run = 1'b1;
            default:   timer_run = 1'b0;
        endcase
    end

    assign us_wrap  = (us_cnt == US_W'(CLK_DIV - 1));
    assign sub_wrap = (sub_cnt == SUB_W'(US_PER_MS - 1));
    assign ms_tick  = timer_run && us_wrap && sub_wrap;

    // A "done" fires on the last cycle of the final millisecond, so the
    // state lasts exactly N ms from the cycle its counters were cleared.
    assign period_done = ms_tick && (ms_cnt == MS_W'(PERIOD_MS - 1));
    assign window_done = ms_tick && (ms_cnt == MS_W'(WINDOW_MS - 1));
    assign retry_done  = ms_tick && (ms_cnt == MS_W'(RETRY_MS - 1));

    always_comb begin
        leave = 1'b0;
        unique case (state)
            IDLE:        leave = req_now || period_done;
            TRIG, CHECK: leave = 1'b1;
            WAIT:        leave = window_done;
            GAP:         leave = retry_done;
            default:     leave = 1'b1;
        endcase
    end

    assign in_range = (humidity_in[15:8] <= 8'd100)
                   && (temperature_in[15:8] <= 8'd60)
                   && ({humidity_in, temperature_in} != 32'd0);
    assign sample_ok = !CHECK_EN || in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            us_cnt      <= '0;
            sub_cnt     <= '0;
            ms_cnt      <= '0;
            retry_cnt   <= '0;
            dht_start   <= 1'b0;
            humidity    <= '0;
            temperature <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
            irq         <= 1'b0;
        end else begin
            dht_start <= 1'b0;
            if (irq_clr) begin
                irq <= 1'b0;
            end

            // Counters restart on every state change.
            if (leave || !timer_run) begin
                us_cnt  <= '0;
                sub_cnt <= '0;
                ms_cnt  <= '0;
            end else begin
                us_cnt <= us_wrap ? '0 : us_cnt + 1'b1;
                if (us_wrap) begin
                    sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
                    if (sub_wrap) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end
            end

            unique case (state)
                IDLE: begin
                    if (req_now || period_done) begin
                        state     <= TRIG;
                        dht_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                TRIG: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (window_done) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (sample_ok) begin
                        humidity    <= humidity_in;
                        temperature <= temperature_in;
                        valid       <= 1'b1;
                        err         <= 1'b0;
                        irq         <= 1'b1;
                        retry_cnt   <= '0;
                    end else begin
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (retry_cnt < RT_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= GAP;
                            busy      <= 1'b1;
                        end else begin
                            err       <= 1'b1;
                            irq       <= 1'b1;
                            retry_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    if (retry_done) begin
                        state     <= TRIG;
                        dht_start <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_scheduler.sv
// tb_dht11_scheduler: directed self-checking bench for dht11_scheduler.
// Uses CLK_DIV=2, US_PER_MS=10, so one ms is 20 clock cycles.
module tb_dht11_scheduler;

    localparam int CLK_DIV   = 2;
    localparam int US_PER_MS = 10;
    localparam int PERIOD_MS = 3;
    localparam int WINDOW_MS = 2;
    localparam int RETRY_MS  = 2;
    localparam int MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req_now;
    logic        irq_clr;
    logic [15:0] humidity_in;
    logic [15:0] temperature_in;
    logic        dht_start;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic        valid;
    logic        busy;
    logic        err;
    logic [7:0]  err_count;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int starts[$];

    dht11_scheduler #(
        .CLK_DIV   (CLK_DIV),
        .US_PER_MS (US_PER_MS),
        .PERIOD_MS (PERIOD_MS),
        .WINDOW_MS (WINDOW_MS),
        .RETRY_MS  (RETRY_MS),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .req_now        (req_now),
        .irq_clr        (irq_clr),
        .humidity_in    (humidity_in),
        .temperature_in (temperature_in),
        .dht_start      (dht_start),
        .humidity       (humidity),
        .temperature    (temperature),
        .valid          (valid),
        .busy           (busy),
        .err            (err),
        .err_count      (err_count),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dht_start === 1'b1) starts.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; req_now = 1'b1; irq_clr = 1'b0;
        humidity_in = 16'h0; temperature_in = 16'h0;
        step(3);
        total++;
        if ({dht_start, valid, busy, err, irq} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b need 00000",
                     {dht_start, valid, busy, err, irq});
        end
        total++;
        if (humidity !== 16'h0 || temperature !== 16'h0
            || err_count !== 8'h0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h need 0 0 0",
                     humidity, temperature, err_count);
        end
        total++;
        if (starts.size() != 0) begin
            bad++;
            $display("FAIL reset_nostart: got %0d pulses need 0",
                     starts.size());
        end
        rst = 1'b0; req_now = 1'b0;
        step(30);
        total++;
        if (busy !== 1'b0 || starts.size() != 0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b pulses=%0d need 0 0",
                     busy, starts.size());
        end
    endtask

    task automatic test_request;
        humidity_in = 16'h3700; temperature_in = 16'h1805;
        req_now = 1'b1;
        step(1);
        req_now = 1'b0;
        total++;
        if (dht_start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL req_start: start=%b busy=%b need 1 1",
                     dht_start, busy);
        end
        step(1);
        total++;
        if (dht_start !== 1'b0) begin
            bad++;
            $display("FAIL req_width: start=%b need 0", dht_start);
        end
        step(40);
        total++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL req_precheck: valid=%b busy=%b need 0 1",
                     valid, busy);
        end
        step(1);
        total++;
        if (humidity !== 16'h3700 || temperature !== 16'h1805) begin
            bad++;
            $display("FAIL req_data: got %h %h need 3700 1805",
                     humidity, temperature);
        end
        total++;
        if ({valid, irq, busy, err} !== 4'b1100) begin
            bad++;
            $display("FAIL req_status: v/i/b/e=%b need 1100",
                     {valid, irq, busy, err});
        end
        total++;
        if (starts.size() != 1) begin
            bad++;
            $display("FAIL req_count: got %0d pulses need 1",
                     starts.size());
        end
    endtask

    task automatic test_irq_contention;
        irq_clr = 1'b1;
        step(1);
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear: irq=%b need 0", irq);
        end
        humidity_in = 16'h6400; temperature_in = 16'h3C00;
        req_now = 1'b1;
        step(1);
        req_now = 1'b0;
        step(41);
        irq_clr = 1'b1;
        step(1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_setwins: irq=%b need 1", irq);
        end
        total++;
        if (humidity !== 16'h6400 || temperature !== 16'h3C00) begin
            bad++;
            $display("FAIL irq_bound_data: got %h %h need 6400 3c00",
                     humidity, temperature);
        end
        step(1);
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_later_clr: irq=%b need 0", irq);
        end
    endtask

    task automatic test_periodic;
        int base;
        int t0;
        int n;
        humidity_in = 16'h2A00; temperature_in = 16'h1900;
        base = starts.size();
        t0 = cyc;
        n = 0;
        en = 1'b1;
        while (starts.size() < base + 2 && n < 400) begin
            step(1);
            n++;
        end
        en = 1'b0;
        total++;
        if (starts.size() < base + 2) begin
            bad++;
            $display("FAIL per_count: got %0d pulses need %0d",
                     starts.size() - base, 2);
        end else begin
            total++;
            if (starts[base] != t0 + 60) begin
                bad++;
                $display("FAIL per_first: at %0d need %0d",
                         starts[base] - t0, 60);
            end
            total++;
            if (starts[base + 1] - starts[base] != 102) begin
                bad++;
                $display("FAIL per_spacing: got %0d need 102",
                         starts[base + 1] - starts[base]);
            end
        end
        wait_idle(200);
        total++;
        if (busy !== 1'b0 || humidity !== 16'h2A00) begin
            bad++;
            $display("FAIL per_end: busy=%b hum=%h need 0 2a00",
                     busy, humidity);
        end
        step(80);
        total++;
        if (starts.size() != base + 2) begin
            bad++;
            $display("FAIL per_stop: got %0d pulses need 2",
                     starts.size() - base);
        end
    endtask

    task automatic test_retry;
        int base;
        irq_clr = 1'b1;
        step(1);
        irq_clr = 1'b0;
        humidity_in = 16'hFF00; temperature_in = 16'h1000;
        base = starts.size();
        req_now = 1'b1;
        step(1);
        req_now = 1'b0;
        wait_idle(400);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL retry_done: busy=%b need 0", busy);
        end
`ifdef DHT_SCHED_PLAUSIBILITY_EN
        total++;
        if (starts.size() != base + 3) begin
            bad++;
            $display("FAIL retry_count: got %0d pulses need 3",
                     starts.size() - base);
        end else begin
            total++;
            if (starts[base + 1] - starts[base] != 82
                || starts[base + 2] - starts[base + 1] != 82) begin
                bad++;
                $display("FAIL retry_gap: got %0d %0d need 82 82",
                         starts[base + 1] - starts[base],
                         starts[base + 2] - starts[base + 1]);
            end
        end
        total++;
        if ({err, irq, valid} !== 3'b111 || err_count !== 8'd3) begin
            bad++;
            $display("FAIL retry_status: e/i/v=%b cnt=%0d need 111 3",
                     {err, irq, valid}, err_count);
        end
        total++;
        if (humidity !== 16'h2A00 || temperature !== 16'h1900) begin
            bad++;
            $display("FAIL retry_hold: got %h %h need 2a00 1900",
                     humidity, temperature);
        end
`else
        total++;
        if (starts.size() != base + 1) begin
            bad++;
            $display("FAIL retry_count: got %0d pulses need 1",
                     starts.size() - base);
        end
        total++;
        if (humidity !== 16'hFF00 || err !== 1'b0
            || err_count !== 8'd0) begin
            bad++;
            $display("FAIL nocheck_accept: hum=%h err=%b cnt=%0d need ff00 0 0",
                     humidity, err, err_count);
        end
`endif
        humidity_in = 16'h3000; temperature_in = 16'h0000;
        req_now = 1'b1;
        step(1);
        req_now = 1'b0;
        wait_idle(200);
        total++;
        if (err !== 1'b0 || humidity !== 16'h3000 || valid !== 1'b1) begin
            bad++;
            $display("FAIL retry_recover: err=%b hum=%h v=%b need 0 3000 1",
                     err, humidity, valid);
        end
`ifdef DHT_SCHED_PLAUSIBILITY_EN
        total++;
        if (err_count !== 8'd3) begin
            bad++;
            $display("FAIL retry_cnt_keep: got %0d need 3", err_count);
        end
`endif
    endtask

    task automatic test_busy_ignore;
        int base;
        humidity_in = 16'h1111; temperature_in = 16'h0A00;
        base = starts.size();
        req_now = 1'b1;
        step(1);
        req_now = 1'b0;
        step(10);
        req_now = 1'b1;
        step(1);
        req_now = 1'b0;
        wait_idle(200);
        step(20);
        total++;
        if (starts.size() != base + 1 || humidity !== 16'h1111) begin
            bad++;
            $display("FAIL ignore_req: pulses=%0d hum=%h need 1 1111",
                     starts.size() - base, humidity);
        end
        humidity_in = 16'h2222; temperature_in = 16'h0B00;
        base = starts.size();
        req_now = 1'b1;
        step(1);
        req_now = 1'b0;
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total++;
        if ({busy, valid} !== 2'b00 || humidity !== 16'h0) begin
            bad++;
            $display("FAIL midreset: busy=%b v=%b hum=%h need 0 0 0",
                     busy, valid, humidity);
        end
        step(60);
        total++;
        if (starts.size() != base + 1 || valid !== 1'b0
            || humidity !== 16'h0) begin
            bad++;
            $display("FAIL midreset_drop: pulses=%0d v=%b hum=%h need 1 0 0",
                     starts.size() - base, valid, humidity);
        end
    endtask

    initial begin
        test_reset();
        test_request();
        test_irq_contention();
        test_periodic();
        test_retry();
        test_busy_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
